// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and defaults for the write-back retirement queue
//
// Purpose: default geometry, the PC register index and the entry layout shared
// by the retirement queue, its forwarding matcher and the bench model.
// Ports: none (package).
package wb_pkg;

  localparam int DEF_DEPTH  = 4;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;

  // r15 is the PC; it is never held in the register file.
  localparam logic [DEF_ADDR_W-1:0] PC_IDX = 4'd15;

  // One queue entry at the default geometry.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] dest;
    logic [DEF_DATA_W-1:0] data;
    logic                  is_load;
    logic                  data_ok;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// rtl/wb_fwd_match.sv - youngest-first forwarding lookup over queue and output register
//
// Purpose: for one source operand, find the youngest in-flight producer.
// Ports:
//   i_src                    operand register index
//   i_head                   index of the oldest queue entry
//   i_vld / i_ok             per-entry valid and data-present flags
//   i_dest / i_data          per-entry destination and data
//   i_out_vld/dest/data      output register (older than every queue entry)
//   o_hit / o_data           forwarded value is usable
//   o_pending                youngest producer is a load still waiting for data
module wb_fwd_match
  import wb_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0]             i_src,
  input  logic [$clog2(DEPTH)-1:0]      i_head,
  input  logic [DEPTH-1:0]              i_vld,
  input  logic [DEPTH-1:0]              i_ok,
  input  logic [DEPTH-1:0][ADDR_W-1:0]  i_dest,
  input  logic [DEPTH-1:0][DATA_W-1:0]  i_data,
  input  logic                          i_out_vld,
  input  logic [ADDR_W-1:0]             i_out_dest,
  input  logic [DATA_W-1:0]             i_out_data,
  output logic                          o_hit,
  output logic [DATA_W-1:0]             o_data,
  output logic                          o_pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] PC_REG = ADDR_W'(PC_IDX);

  logic [PTR_W-1:0] w_idx;

  // Walk oldest to youngest and let each later match overwrite the earlier
  // one, so the youngest producer wins. Valid entries are contiguous from head.
  always_comb begin
    o_hit     = 1'b0;
    o_data    = '0;
    o_pending = 1'b0;
    w_idx     = i_head;
    if (i_src != PC_REG) begin
      if (i_out_vld && (i_out_dest == i_src)) begin
        o_hit  = 1'b1;
        o_data = i_out_data;
      end
      for (int k = 0; k < DEPTH; k++) begin
        w_idx = i_head + PTR_W'(k);
        if (i_vld[w_idx] && (i_dest[w_idx] == i_src)) begin
          o_hit     = i_ok[w_idx];
          o_data    = i_ok[w_idx] ? i_data[w_idx] : '0;
          o_pending = !i_ok[w_idx];
        end
      end
    end
  end

endmodule

// File: rtl/wb_retire_queue.sv
// rtl/wb_retire_queue.sv - in-order write-back retirement queue with forwarding
//
// Purpose: buffers MEM-stage results in program order, waits for load data,
// retires one entry per cycle into the register-file write port.
// Optional macro: WB_PROTOCOL_CHECK_EN adds sticky output proto_err.
// Ports:
//   clk, rst (sync, active-low)
//   in_valid/in_ready, in_wb_en, in_is_load, in_dest, in_result   enqueue side
//   ld_data_valid, ld_data                                         in-order SRAM data
//   fwd_src1/2 -> fwd1/2_hit, fwd1/2_data, ld_use_stall            forwarding
//   writeBackEn, dest_wb, Result_WB                                register-file port
//   count                                                          occupancy
module wb_retire_queue
  import wb_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_wb_en,
  input  logic                     in_is_load,
  input  logic [ADDR_W-1:0]        in_dest,
  input  logic [DATA_W-1:0]        in_result,
  input  logic                     ld_data_valid,
  input  logic [DATA_W-1:0]        ld_data,
  input  logic [ADDR_W-1:0]        fwd_src1,
  input  logic [ADDR_W-1:0]        fwd_src2,
  output logic                     fwd1_hit,
  output logic                     fwd2_hit,
  output logic [DATA_W-1:0]        fwd1_data,
  output logic [DATA_W-1:0]        fwd2_data,
  output logic                     ld_use_stall,
  output logic                     writeBackEn,
  output logic [ADDR_W-1:0]        dest_wb,
  output logic [DATA_W-1:0]        Result_WB,
  output logic [$clog2(DEPTH):0]   count
`ifdef WB_PROTOCOL_CHECK_EN
  ,
  output logic                     proto_err
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] PC_REG = ADDR_W'(PC_IDX);

  logic [PTR_W-1:0]             r_head;
  logic [PTR_W-1:0]             r_tail;
  logic [PTR_W:0]               r_count;
  logic [DEPTH-1:0]             r_vld;
  // Non-loads are created with data_ok=1, so "load awaiting data" is just
  // valid && !data_ok; no separate is_load bit needs to be stored.
  logic [DEPTH-1:0]             r_ok;
  logic [DEPTH-1:0][ADDR_W-1:0] r_dest;
  logic [DEPTH-1:0][DATA_W-1:0] r_data;
  logic                         r_wb_en;
  logic [ADDR_W-1:0]            r_wb_dest;
  logic [DATA_W-1:0]            r_wb_data;

  logic                         w_accept;
  logic                         w_create;
  logic                         w_retire;
  logic                         w_fill_hit;
  logic [PTR_W-1:0]             w_fill_idx;
  logic [PTR_W-1:0]             w_scan_idx;
  logic                         w_fill_old;
  logic                         w_fill_new;
  logic                         w_pend1;
  logic                         w_pend2;

  assign in_ready = (r_count != (PTR_W+1)'(DEPTH));
  assign w_accept = in_valid && in_ready;
  assign w_create = w_accept && in_wb_en && (in_dest != PC_REG);
  // Uses registered data_ok, so a head filled this edge retires next edge.
  assign w_retire = r_vld[r_head] && r_ok[r_head];

  // Oldest load still waiting for data.
  always_comb begin
    w_fill_hit = 1'b0;
    w_fill_idx = r_head;
    w_scan_idx = r_head;
    for (int k = 0; k < DEPTH; k++) begin
      w_scan_idx = r_head + PTR_W'(k);
      if (!w_fill_hit && r_vld[w_scan_idx] && !r_ok[w_scan_idx]) begin
        w_fill_hit = 1'b1;
        w_fill_idx = w_scan_idx;
      end
    end
  end

  assign w_fill_old = ld_data_valid && w_fill_hit;
  assign w_fill_new = ld_data_valid && !w_fill_hit && w_create && in_is_load;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_vld     <= '0;
      r_ok      <= '0;
      r_dest    <= '0;
      r_data    <= '0;
      r_wb_en   <= 1'b0;
      r_wb_dest <= '0;
      r_wb_data <= '0;
    end else begin
      if (w_retire) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + 1'b1;
        r_wb_dest     <= r_dest[r_head];
        r_wb_data     <= r_data[r_head];
      end
      r_wb_en <= w_retire;
      if (w_create) begin
        r_vld[r_tail]  <= 1'b1;
        r_dest[r_tail] <= in_dest;
        r_ok[r_tail]   <= !in_is_load || w_fill_new;
        r_data[r_tail] <= w_fill_new ? ld_data : in_result;
        r_tail         <= r_tail + 1'b1;
      end
      if (w_fill_old) begin
        r_ok[w_fill_idx]   <= 1'b1;
        r_data[w_fill_idx] <= ld_data;
      end
      r_count <= r_count + (PTR_W+1)'(w_create) - (PTR_W+1)'(w_retire);
    end
  end

`ifdef WB_PROTOCOL_CHECK_EN
  logic r_proto_err;
  logic w_drop;

  assign w_drop = ld_data_valid && !w_fill_old && !w_fill_new;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_proto_err <= 1'b0;
    end else if (w_drop || (in_valid && in_is_load && !in_wb_en)) begin
      r_proto_err <= 1'b1;
    end
  end

  assign proto_err = r_proto_err;
`endif

  wb_fwd_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd1 (
    .i_src      (fwd_src1),
    .i_head     (r_head),
    .i_vld      (r_vld),
    .i_ok       (r_ok),
    .i_dest     (r_dest),
    .i_data     (r_data),
    .i_out_vld  (r_wb_en),
    .i_out_dest (r_wb_dest),
    .i_out_data (r_wb_data),
    .o_hit      (fwd1_hit),
    .o_data     (fwd1_data),
    .o_pending  (w_pend1)
  );

  wb_fwd_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd2 (
    .i_src      (fwd_src2),
    .i_head     (r_head),
    .i_vld      (r_vld),
    .i_ok       (r_ok),
    .i_dest     (r_dest),
    .i_data     (r_data),
    .i_out_vld  (r_wb_en),
    .i_out_dest (r_wb_dest),
    .i_out_data (r_wb_data),
    .o_hit      (fwd2_hit),
    .o_data     (fwd2_data),
    .o_pending  (w_pend2)
  );

  assign ld_use_stall = w_pend1 || w_pend2;
  assign writeBackEn  = r_wb_en;
  assign dest_wb      = r_wb_dest;
  assign Result_WB    = r_wb_data;
  assign count        = r_count;

endmodule

// File: tb/tb_wb_retire_queue.sv
// tb/tb_wb_retire_queue.sv - randomized bench for wb_retire_queue against a queue model
module tb_wb_retire_queue;
  import wb_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_wb_en, in_is_load;
  logic [3:0]  in_dest;
  logic [31:0] in_result;
  logic        ld_data_valid;
  logic [31:0] ld_data;
  logic [3:0]  fwd_src1, fwd_src2;
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd1_data, fwd2_data;
  logic        ld_use_stall;
  logic        writeBackEn;
  logic [3:0]  dest_wb;
  logic [31:0] Result_WB;
  logic [2:0]  count;
`ifdef WB_PROTOCOL_CHECK_EN
  logic        proto_err;
`endif

  wb_retire_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_wb_en      (in_wb_en),
    .in_is_load    (in_is_load),
    .in_dest       (in_dest),
    .in_result     (in_result),
    .ld_data_valid (ld_data_valid),
    .ld_data       (ld_data),
    .fwd_src1      (fwd_src1),
    .fwd_src2      (fwd_src2),
    .fwd1_hit      (fwd1_hit),
    .fwd2_hit      (fwd2_hit),
    .fwd1_data     (fwd1_data),
    .fwd2_data     (fwd2_data),
    .ld_use_stall  (ld_use_stall),
    .writeBackEn   (writeBackEn),
    .dest_wb       (dest_wb),
    .Result_WB     (Result_WB),
    .count         (count)
`ifdef WB_PROTOCOL_CHECK_EN
    ,
    .proto_err     (proto_err)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: program-order list of in-flight entries (front = oldest)
  // plus the register-file write port contents.
  wb_entry_t   mq[$];
  bit          m_wb_en;
  logic [3:0]  m_dest;
  logic [31:0] m_res;
  bit          m_perr;

  function automatic void m_fwd(input logic [3:0] src, output bit hit,
                                output logic [31:0] d, output bit pend);
    hit = 0; d = '0; pend = 0;
    if (src == 4'd15) return;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].dest == src) begin
        if (mq[i].data_ok) begin
          hit = 1; d = mq[i].data;
        end else begin
          pend = 1;
        end
        return;
      end
    end
    if (m_wb_en && m_dest == src) begin
      hit = 1; d = m_res;
    end
  endfunction

  task automatic model_edge();
    bit        retire, create, filled;
    wb_entry_t ne, t;
    if (!rst) begin
      mq.delete();
      m_wb_en = 0; m_dest = '0; m_res = '0; m_perr = 0;
      return;
    end
    retire = (mq.size() > 0) && mq[0].data_ok;
    create = in_valid && (mq.size() < DEPTH) && in_wb_en && (in_dest != 4'd15);
    ne.dest = in_dest; ne.data = in_result; ne.is_load = in_is_load; ne.data_ok = !in_is_load;
    if (in_valid && in_is_load && !in_wb_en) m_perr = 1;
    if (ld_data_valid) begin
      filled = 0;
      for (int i = 0; i < mq.size(); i++) begin
        if (!filled && mq[i].is_load && !mq[i].data_ok) begin
          t = mq[i]; t.data_ok = 1; t.data = ld_data; mq[i] = t;
          filled = 1;
        end
      end
      if (!filled) begin
        if (create && in_is_load) begin
          ne.data_ok = 1; ne.data = ld_data;
        end else begin
          m_perr = 1;
        end
      end
    end
    if (retire) begin
      m_wb_en = 1; m_dest = mq[0].dest; m_res = mq[0].data;
      void'(mq.pop_front());
    end else begin
      m_wb_en = 0;
    end
    if (create) mq.push_back(ne);
  endtask

  task automatic check_outputs();
    bit h1, h2, p1, p2;
    logic [31:0] d1, d2;
    m_fwd(fwd_src1, h1, d1, p1);
    m_fwd(fwd_src2, h2, d2, p2);
    chk("in_ready", in_ready, mq.size() < DEPTH);
    chk("count", count, mq.size());
    chk("writeBackEn", writeBackEn, m_wb_en);
    chk("dest_wb", dest_wb, m_dest);
    chk("Result_WB", Result_WB, m_res);
    chk("fwd1_hit", fwd1_hit, h1);
    chk("fwd1_data", fwd1_data, d1);
    chk("fwd2_hit", fwd2_hit, h2);
    chk("fwd2_data", fwd2_data, d2);
    chk("ld_use_stall", ld_use_stall, p1 || p2);
`ifdef WB_PROTOCOL_CHECK_EN
    chk("proto_err", proto_err, m_perr);
`endif
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_wb_en = 0; in_is_load = 0; in_dest = '0; in_result = '0;
    ld_data_valid = 0; ld_data = '0;
  endtask

  task automatic push(input bit ld, input logic [3:0] d, input logic [31:0] v);
    in_valid = 1; in_wb_en = 1; in_is_load = ld; in_dest = d; in_result = v;
    ld_data_valid = 0;
  endtask

  initial begin
    rst = 0; idle(); fwd_src1 = '0; fwd_src2 = '0;
    #1;
    // Reset held two cycles, then released with no input.
    cycle(); cycle();
    rst = 1;
    cycle(); cycle();
    @(negedge clk);
    chk("rst_wb_en", writeBackEn, 0);
    chk("rst_dest", dest_wb, 0);
    chk("rst_res", Result_WB, 0);
    chk("rst_count", count, 0);
    chk("rst_ready", in_ready, 1);
    @(posedge clk); model_edge(); #1;

    // Single ALU result: r3 = 0x55.
    fwd_src1 = 4'd3; fwd_src2 = 4'd4;
    push(0, 4'd3, 32'h55); cycle();
    idle(); repeat (3) cycle();

    // Load r1, ALU r2 = 7, load data arrives later.
    fwd_src1 = 4'd1; fwd_src2 = 4'd2;
    push(1, 4'd1, 32'hDEAD); cycle();
    push(0, 4'd2, 32'd7); cycle();
    idle(); repeat (2) cycle();
    ld_data_valid = 1; ld_data = 32'hA0; cycle();
    idle(); repeat (3) cycle();

    // Two producers of r5; youngest forwards, then the output register.
    fwd_src1 = 4'd5; fwd_src2 = 4'd15;
    push(0, 4'd5, 32'd1); cycle();
    push(0, 4'd5, 32'd2); cycle();
    idle(); repeat (4) cycle();

    // Fill with four loads while in_valid is held, then return data 1..4.
    fwd_src1 = 4'd9; fwd_src2 = 4'd11;
    for (int k = 0; k < 6; k++) begin
      push(1, 4'(8 + ((k < 3) ? k : 3)), 32'h0);
      cycle();
    end
    idle();
    for (int k = 1; k <= 4; k++) begin
      ld_data_valid = 1; ld_data = 32'(k); cycle();
    end
    idle(); repeat (4) cycle();

    // PC destination creates nothing; reset with a load pending; late beat.
    fwd_src1 = 4'd15; fwd_src2 = 4'd4;
    push(0, 4'd15, 32'h1234); cycle();
    push(1, 4'd4, 32'h0); cycle();
    idle(); cycle();
    rst = 0; ld_data_valid = 1; ld_data = 32'h77; cycle();
    rst = 1; idle(); cycle();
    ld_data_valid = 1; ld_data = 32'h88; cycle();
    idle(); repeat (2) cycle();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 199) != 0);
      in_valid      = ($urandom_range(0, 99) < 60);
      in_wb_en      = ($urandom_range(0, 99) < 90);
      in_is_load    = ($urandom_range(0, 99) < 35);
      in_dest       = 4'($urandom_range(0, 15));
      in_result     = $urandom;
      ld_data_valid = ($urandom_range(0, 99) < 35);
      ld_data       = $urandom;
      fwd_src1      = 4'($urandom_range(0, 15));
      fwd_src2      = 4'($urandom_range(0, 15));
      cycle();
    end
    rst = 1; idle(); repeat (8) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
